move_win_scanner: RTL and testbench
===================================

Name: move_win_scanner

Overview:
- Sequential five-in-a-row checker placed directly downstream of the player and AI move generators.
- On each completed move it walks the mover's stone bitmap outward from the placed cell in four directions, one cell per clock.
- It reports win, direction and run length to the game controller that drives the who_win register.
- It replaces a wide combinational checker with a small FSM and one latched board copy.

Parameters:
- N, 15, board edge length; cell index = row*N + col.
- WIN_LEN, 5, stones in a line needed to win.

Ports:
- clk  input  1  scan clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse: a move was placed at row/col.
- row  input  4  placed stone row, 0..N-1.
- col  input  4  placed stone column, 0..N-1.
- board  input  N*N  mover's stones; bit=1 means a stone is present.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse: result valid.
- win  output  1  result: mover completed a line.
- bad  output  1  result: illegal request (off-board, or the placed cell is empty).
- win_dir  output  2  winning direction: 0 horizontal, 1 vertical, 2 diagonal (+1,+1), 3 anti-diagonal (+1,-1).
- run_len  output  5  stone count of the last evaluated line.

Behaviour:
- Reset (async, rst=0): state IDLE; busy, done, win, bad = 0; win_dir = 0; run_len = 0. Reset mid-scan aborts the scan immediately; no done is issued.
- IDLE: on clk edge with start=1, latch board, row and col; go to CHECK; busy=1.
- start while busy=1: ignored, no queueing.
- CHECK (1 cycle):
  - If row>=N, col>=N, or the latched cell is 0: go to DONE with bad=1, win=0, run_len=0.
  - Else: dir=0, count=1, go to POS.
- POS: each cycle probes one cell at offset +k along dir (k=1,2,..).
  - Stone present: count+1, k+1.
  - Off-board or empty: go to NEG with k=1. An off-board probe still costs its cycle.
  - Early exit: as soon as count reaches WIN_LEN, go to EVAL.
- NEG: same rules at offset -k, then go to EVAL.
- EVAL (combinational, 0 cycles, taken at the end of NEG or on early exit):
  - If count >= WIN_LEN: win=1, win_dir=dir, run_len=count, go to DONE. Remaining directions are skipped.
  - Else if dir<3: dir+1, count=1, go to POS.
  - Else: win=0, run_len = count of dir 3, go to DONE.
- DONE (1 cycle): done=1, busy=0, return to IDLE.
- Result outputs (win, bad, win_dir, run_len) hold until the next accepted start, which clears them.
- Latency: done asserts 2+P clocks after the start-sampling edge, where P = number of probe cycles.
- Column arithmetic: out-of-range checks are done on signed 6-bit coordinates, so 0-1 is off-board, never a wrap to 15.
- count saturates at 31.
- Live board changes during a scan do not affect the result (the scan uses the latched copy).

Optional Feature:
- Macro: WIN_EXACT_EN.
- Defined: exact-five rule. The early exit at WIN_LEN is removed; each walk continues to an empty or off-board cell. Win requires count == WIN_LEN exactly; an overline of 6 or more does not win, and scanning continues with the next direction.
- Undefined: count >= WIN_LEN wins, with early exit.

Test Plan:
- Single stone at (7,7), start -> 8 probes; done at cycle 10; win=0, bad=0, run_len=1.
- Stones (7,3)..(7,7), start at (7,7) -> 1 POS probe + 4 NEG probes; done at cycle 7; win=1, win_dir=0, run_len=5.
- Stones (0,14),(1,13),(2,12),(3,11),(4,10), start at (2,12) -> directions 0..2 fail, then win=1, win_dir=3, run_len=5. No wrap: check that (0,0) or (x,15) never counts.
- Stones (9,0)..(9,5), start at (9,0) -> without WIN_EXACT_EN: win=1, run_len=5. With WIN_EXACT_EN: win=0, and dir 0 count=6 is rejected.
- Start at (5,5) with the cell empty -> done at cycle 2, bad=1, win=0. Start with row=15 -> bad=1.
- Pull rst low during POS, then start a new scan -> done never pulses for the aborted scan; outputs 0; the next scan returns a correct result. A second start pulse issued while busy=1 -> ignored.

Source files
------------

// File: rtl/move_win_scanner_if.sv
// Move/result bus between the move generators, move_win_scanner and the game controller.
interface move_win_scanner_if #(
    parameter int unsigned N = 15
);
    logic             start;
    logic [3:0]       row;
    logic [3:0]       col;
    logic [N*N-1:0]   board;
    logic             busy;
    logic             done;
    logic             win;
    logic             bad;
    logic [1:0]       win_dir;
    logic [4:0]       run_len;

    modport master (
        output start, row, col, board,
        input  busy, done, win, bad, win_dir, run_len
    );

    modport slave (
        input  start, row, col, board,
        output busy, done, win, bad, win_dir, run_len
    );
endinterface

// File: rtl/move_win_scanner.sv
// Sequential five-in-a-row checker: walks the latched board outward from the placed cell, one probe per clock.
// Define WIN_EXACT_EN for the exact-five rule (no early exit, overlines do not win).
module move_win_scanner #(
    parameter int unsigned N       = 15,
    parameter int unsigned WIN_LEN = 5
) (
    input  logic              clk,
    input  logic              rst,
    move_win_scanner_if.slave bus
);
    localparam int unsigned CELLS = N * N;
    localparam int unsigned IDX_W = $clog2(CELLS);
    localparam int unsigned CW    = 5;
    localparam int unsigned PW    = 6;

`ifdef WIN_EXACT_EN
    localparam bit EXACT = 1'b1;
`else
    localparam bit EXACT = 1'b0;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_POS   = 3'd2;
    localparam logic [2:0] S_NEG   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              state, state_d;
    logic [CELLS-1:0]        brd_q, brd_d;
    logic [3:0]              row_q, row_d, col_q, col_d;
    logic signed [PW-1:0]    pr, pr_d, pc, pc_d;
    logic [1:0]              dir, dir_d, dir_nx;
    logic [CW-1:0]           cnt, cnt_d, cnt_inc;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    win_q, win_d, bad_q, bad_d;
    logic [1:0]              win_dir_q, win_dir_d;
    logic [CW-1:0]           run_len_q, run_len_d;

    logic signed [PW-1:0]    sr_c, sc_c;
    logic                    in_range_c, on_board_c, stone_c, early_c, hit_c, eval_c;
    logic [IDX_W-1:0]        cell_idx_c, probe_idx_c;

    // Step along a direction: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal.
    function automatic logic signed [PW-1:0] d_row(input logic [1:0] d);
        return (d == 2'd0) ? 6'sd0 : 6'sd1;
    endfunction

    function automatic logic signed [PW-1:0] d_col(input logic [1:0] d);
        case (d)
            2'd0:    return 6'sd1;
            2'd1:    return 6'sd0;
            2'd2:    return 6'sd1;
            default: return -6'sd1;
        endcase
    endfunction

    // Coordinates stay signed so stepping left of column 0 lands off-board instead of wrapping.
    always_comb begin
        sr_c        = $signed({2'b00, row_q});
        sc_c        = $signed({2'b00, col_q});
        in_range_c  = (32'(row_q) < N) && (32'(col_q) < N);
        cell_idx_c  = IDX_W'(row_q) * IDX_W'(N) + IDX_W'(col_q);
        on_board_c  = !pr[PW-1] && !pc[PW-1] && (32'(pr[PW-2:0]) < N) && (32'(pc[PW-2:0]) < N);
        probe_idx_c = IDX_W'(pr[PW-2:0]) * IDX_W'(N) + IDX_W'(pc[PW-2:0]);
        stone_c     = on_board_c && brd_q[probe_idx_c];
        cnt_inc     = (cnt == 5'd31) ? cnt : cnt + 5'd1;
        early_c     = !EXACT && (32'(cnt_inc) >= WIN_LEN);
        dir_nx      = dir + 2'd1;
    end

    always_comb begin
        state_d   = state;
        brd_d     = brd_q;
        row_d     = row_q;
        col_d     = col_q;
        pr_d      = pr;
        pc_d      = pc;
        dir_d     = dir;
        cnt_d     = cnt;
        busy_d    = busy_q;
        done_d    = 1'b0;
        win_d     = win_q;
        bad_d     = bad_q;
        win_dir_d = win_dir_q;
        run_len_d = run_len_q;
        eval_c    = 1'b0;
        hit_c     = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    brd_d     = bus.board;
                    row_d     = bus.row;
                    col_d     = bus.col;
                    busy_d    = 1'b1;
                    win_d     = 1'b0;
                    bad_d     = 1'b0;
                    win_dir_d = 2'd0;
                    run_len_d = '0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!in_range_c || !brd_q[cell_idx_c]) begin
                    bad_d     = 1'b1;
                    win_d     = 1'b0;
                    run_len_d = '0;
                    state_d   = S_DONE;
                end else begin
                    dir_d   = 2'd0;
                    cnt_d   = 5'd1;
                    pr_d    = sr_c + d_row(2'd0);
                    pc_d    = sc_c + d_col(2'd0);
                    state_d = S_POS;
                end
            end
            S_POS: begin
                if (stone_c) begin
                    cnt_d  = cnt_inc;
                    pr_d   = pr + d_row(dir);
                    pc_d   = pc + d_col(dir);
                    eval_c = early_c;
                end else begin
                    pr_d    = sr_c - d_row(dir);
                    pc_d    = sc_c - d_col(dir);
                    state_d = S_NEG;
                end
            end
            S_NEG: begin
                if (stone_c) begin
                    cnt_d  = cnt_inc;
                    pr_d   = pr - d_row(dir);
                    pc_d   = pc - d_col(dir);
                    eval_c = early_c;
                end else begin
                    eval_c = 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Line finished: decide win, move to the next direction, or give up.
        if (eval_c) begin
            hit_c = EXACT ? (32'(cnt_d) == WIN_LEN) : (32'(cnt_d) >= WIN_LEN);
            if (hit_c) begin
                win_d     = 1'b1;
                win_dir_d = dir;
                run_len_d = cnt_d;
                state_d   = S_DONE;
            end else if (dir != 2'd3) begin
                dir_d   = dir_nx;
                cnt_d   = 5'd1;
                pr_d    = sr_c + d_row(dir_nx);
                pc_d    = sc_c + d_col(dir_nx);
                state_d = S_POS;
            end else begin
                win_d     = 1'b0;
                run_len_d = cnt_d;
                state_d   = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            brd_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pr        <= '0;
            pc        <= '0;
            dir       <= '0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            bad_q     <= 1'b0;
            win_dir_q <= '0;
            run_len_q <= '0;
        end else begin
            state     <= state_d;
            brd_q     <= brd_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pr        <= pr_d;
            pc        <= pc_d;
            dir       <= dir_d;
            cnt       <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            win_q     <= win_d;
            bad_q     <= bad_d;
            win_dir_q <= win_dir_d;
            run_len_q <= run_len_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.win     = win_q;
    assign bus.bad     = bad_q;
    assign bus.win_dir = win_dir_q;
    assign bus.run_len = run_len_q;
endmodule

// File: tb/tb_move_win_scanner.sv
// Directed bench for move_win_scanner; expected latencies/results are hand-derived (WIN_EXACT_EN aware).
module tb_move_win_scanner;
    logic clk;
    logic rst;
    logic [224:0] brd;
    int checks;
    int failures;
    int cyc;
    logic [8:0] res;
    logic win_at_1;

`ifdef WIN_EXACT_EN
    localparam int LAT_H  = 8;
    localparam int LAT_AD = 14;
    localparam int LAT_OL = 15;
    localparam logic [8:0] RES_OL = {1'b0, 1'b0, 2'd0, 5'd1};
`else
    localparam int LAT_H  = 7;
    localparam int LAT_AD = 13;
    localparam int LAT_OL = 6;
    localparam logic [8:0] RES_OL = {1'b1, 1'b0, 2'd0, 5'd5};
`endif

    move_win_scanner_if #(.N(15)) bus ();

    move_win_scanner #(.N(15), .WIN_LEN(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic put(input int r, input int c);
        brd[r*15+c] = 1'b1;
    endtask

    // Issue one start and wait (bounded) for done; cyc = edges after the sampling edge, -1 on timeout.
    task automatic scan(input int r, input int c);
        @(negedge clk);
        bus.row   = 4'(r);
        bus.col   = 4'(c);
        bus.board = brd;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        win_at_1 = 1'bx;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) win_at_1 = bus.win;
            if (bus.done) break;
        end
        if (!bus.done) cyc = -1;
        res = {bus.win, bus.bad, bus.win_dir, bus.run_len};
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.win, bus.bad, bus.win_dir, bus.run_len} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {bus.busy, bus.done, bus.win, bus.bad, bus.win_dir, bus.run_len});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        brd = '0;
        put(7, 7);
        scan(7, 7);
        checks++;
        if (cyc !== 10) begin failures++; $display("FAIL single_latency got=%0d want=10", cyc); end
        checks++;
        if (res !== {1'b0, 1'b0, 2'd0, 5'd1}) begin failures++; $display("FAIL single_result got=%b want=%b", res, {1'b0, 1'b0, 2'd0, 5'd1}); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_at_done got=%b want=0", bus.busy); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b want=0", bus.done); end
    endtask

    task automatic test_horizontal();
        brd = '0;
        for (int c = 3; c <= 7; c++) put(7, c);
        scan(7, 7);
        checks++;
        if (cyc !== LAT_H) begin failures++; $display("FAIL horiz_latency got=%0d want=%0d", cyc, LAT_H); end
        checks++;
        if (res !== {1'b1, 1'b0, 2'd0, 5'd5}) begin failures++; $display("FAIL horiz_result got=%b want=%b", res, {1'b1, 1'b0, 2'd0, 5'd5}); end
    endtask

    task automatic test_anti_diag();
        brd = '0;
        for (int i = 0; i < 5; i++) put(i, 14 - i);
        put(0, 0);
        scan(2, 12);
        checks++;
        if (cyc !== LAT_AD) begin failures++; $display("FAIL antidiag_latency got=%0d want=%0d", cyc, LAT_AD); end
        checks++;
        if (res !== {1'b1, 1'b0, 2'd3, 5'd5}) begin failures++; $display("FAIL antidiag_result got=%b want=%b", res, {1'b1, 1'b0, 2'd3, 5'd5}); end
    endtask

    // (2,14) sits where (3,-1) would land if the column wrapped.
    task automatic test_no_wrap();
        brd = '0;
        for (int c = 0; c < 4; c++) put(3, c);
        put(2, 14);
        scan(3, 0);
        checks++;
        if (cyc !== 13) begin failures++; $display("FAIL nowrap_latency got=%0d want=13", cyc); end
        checks++;
        if (res !== {1'b0, 1'b0, 2'd0, 5'd1}) begin failures++; $display("FAIL nowrap_result got=%b want=%b", res, {1'b0, 1'b0, 2'd0, 5'd1}); end
    endtask

    task automatic test_overline();
        brd = '0;
        for (int c = 0; c <= 5; c++) put(9, c);
        scan(9, 0);
        checks++;
        if (cyc !== LAT_OL) begin failures++; $display("FAIL overline_latency got=%0d want=%0d", cyc, LAT_OL); end
        checks++;
        if (res !== RES_OL) begin failures++; $display("FAIL overline_result got=%b want=%b", res, RES_OL); end
    endtask

    task automatic test_bad();
        brd = '0;
        put(5, 6);
        scan(5, 5);
        checks++;
        if (cyc !== 2) begin failures++; $display("FAIL bad_empty_latency got=%0d want=2", cyc); end
        checks++;
        if (res !== {1'b0, 1'b1, 2'd0, 5'd0}) begin failures++; $display("FAIL bad_empty_result got=%b want=%b", res, {1'b0, 1'b1, 2'd0, 5'd0}); end
        brd = '1;
        scan(15, 3);
        checks++;
        if (cyc !== 2 || res !== {1'b0, 1'b1, 2'd0, 5'd0}) begin
            failures++; $display("FAIL bad_row15 got=%0d/%b want=2/%b", cyc, res, {1'b0, 1'b1, 2'd0, 5'd0});
        end
        scan(0, 15);
        checks++;
        if (cyc !== 2 || res !== {1'b0, 1'b1, 2'd0, 5'd0}) begin
            failures++; $display("FAIL bad_col15 got=%0d/%b want=2/%b", cyc, res, {1'b0, 1'b1, 2'd0, 5'd0});
        end
    endtask

    task automatic test_back_to_back();
        brd = '0;
        for (int c = 3; c <= 7; c++) put(7, c);
        scan(7, 5);
        checks++;
        if (res !== {1'b1, 1'b0, 2'd0, 5'd5}) begin failures++; $display("FAIL b2b_first got=%b want=%b", res, {1'b1, 1'b0, 2'd0, 5'd5}); end
        scan(0, 0);
        checks++;
        if (win_at_1 !== 1'b0) begin failures++; $display("FAIL b2b_win_cleared got=%b want=0", win_at_1); end
        checks++;
        if (res !== {1'b0, 1'b1, 2'd0, 5'd0}) begin failures++; $display("FAIL b2b_second got=%b want=%b", res, {1'b0, 1'b1, 2'd0, 5'd0}); end
    endtask

    // Second start and a live board wipe mid-scan must not disturb the running scan.
    task automatic test_busy_ignore();
        brd = '0;
        put(7, 7);
        @(negedge clk);
        bus.row = 4'd7; bus.col = 4'd7; bus.board = brd; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 3) begin
                checks++;
                if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_mid_scan got=%b want=1", bus.busy); end
                bus.row = 4'd5; bus.col = 4'd5; bus.board = '0; bus.start = 1'b1;
            end
            if (cyc == 4) bus.start = 1'b0;
            if (bus.done) break;
        end
        if (!bus.done) cyc = -1;
        checks++;
        if (cyc !== 10) begin failures++; $display("FAIL ignore_latency got=%0d want=10", cyc); end
        checks++;
        if ({bus.win, bus.bad, bus.win_dir, bus.run_len} !== {1'b0, 1'b0, 2'd0, 5'd1}) begin
            failures++; $display("FAIL ignore_result got=%b want=%b", {bus.win, bus.bad, bus.win_dir, bus.run_len}, {1'b0, 1'b0, 2'd0, 5'd1});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignore_no_queue busy=%b want=0", bus.busy); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        brd = '0;
        put(7, 7);
        @(negedge clk);
        bus.row = 4'd7; bus.col = 4'd7; bus.board = brd; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.win, bus.bad, bus.win_dir, bus.run_len} !== 11'd0) begin
            failures++;
            $display("FAIL abort_outputs got=%b want=0", {bus.busy, bus.done, bus.win, bus.bad, bus.win_dir, bus.run_len});
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL abort_no_done got=%0d pulses want=0", pulses); end
        brd = '0;
        for (int c = 3; c <= 7; c++) put(7, c);
        scan(7, 7);
        checks++;
        if (cyc !== LAT_H || res !== {1'b1, 1'b0, 2'd0, 5'd5}) begin
            failures++; $display("FAIL abort_rescan got=%0d/%b want=%0d/%b", cyc, res, LAT_H, {1'b1, 1'b0, 2'd0, 5'd5});
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        checks = 0;
        failures = 0;
        brd = '0;
        bus.start = 1'b0;
        bus.row = '0;
        bus.col = '0;
        bus.board = '0;
        test_reset();
        test_single();
        test_horizontal();
        test_anti_diag();
        test_no_wrap();
        test_overline();
        test_bad();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
